pipe_stage_latch: RTL

Parametrised pipeline-boundary register that generalises the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into a single block. It carries a datapath bus, a control bus and the instruction word, and adds a valid bit, flush, and bubble injection with a per-bit kill mask. It also carries a free-running sticky field that ignores the enable. Instantiated once per stage boundary in the 16-bit pipelined processor.

---
 rtl/pipe_stage_latch.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch
//   One register block for every boundary between pipeline stages. It
//   carries the datapath bus, the control bus and the instruction word,
//   together with a valid bit. It can also flush the stage or inject a
//   bubble, and a per-bit kill mask selects which control bits are cleared.
//   A separate sticky field is loaded on every edge and ignores en.
//
//   Optional build macro: PIPE_STAGE_PERF_EN
//     defined   -> the saturating bubble and hold counters are built
//     undefined -> no counter flops are built and both outputs read 0
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   en            load enable (0 = hold the main fields)
//   stall         inject a bubble in place of the incoming instruction
//   flush         kill the stage contents; this also works while en=0
//   valid_in      the upstream stage holds a real instruction
//   instr_in      incoming instruction word
//   data_in       incoming datapath bus
//   ctrl_in       incoming control bus
//   sticky_in     field loaded on every edge
//   valid_out     the stage holds a real instruction
//   instr_out     instruction word, or NOP_INSTR for a bubble
//   instr_raw_out instruction as received, never replaced by NOP
//   data_out      registered datapath bus
//   ctrl_out      registered control bus after kill masking
//   sticky_out    registered sticky field
//   bubble_cnt    saturating count of bubbles latched
//   hold_cnt      saturating count of consecutive hold cycles

module pipe_stage_latch #(
   parameter int                  DATA_W    = 64,
   parameter int                  CTRL_W    = 16,
   parameter int                  INSTR_W   = 16,
   parameter int                  STICKY_W  = 1,
   parameter logic [CTRL_W-1:0]   KILL_MASK = {CTRL_W{1'b1}},
   parameter logic [INSTR_W-1:0]  NOP_INSTR = INSTR_W'(16'h0800),
   parameter int                  CNT_W     = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                stall,
   input  logic                flush,
   input  logic                valid_in,
   input  logic [INSTR_W-1:0]  instr_in,
   input  logic [DATA_W-1:0]   data_in,
   input  logic [CTRL_W-1:0]   ctrl_in,
   input  logic [STICKY_W-1:0] sticky_in,
   output logic                valid_out,
   output logic [INSTR_W-1:0]  instr_out,
   output logic [INSTR_W-1:0]  instr_raw_out,
   output logic [DATA_W-1:0]   data_out,
   output logic [CTRL_W-1:0]   ctrl_out,
   output logic [STICKY_W-1:0] sticky_out,
   output logic [CNT_W-1:0]    bubble_cnt,
   output logic [CNT_W-1:0]    hold_cnt
);

   // Flush kills whatever the stage already holds. Its data and raw
   // instruction stay put, and only the masked control bits are cleared.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out     <= 1'b0;
         instr_out     <= NOP_INSTR;
         instr_raw_out <= '0;
         data_out      <= '0;
         ctrl_out      <= '0;
      end else if (flush) begin
         valid_out <= 1'b0;
         instr_out <= NOP_INSTR;
         ctrl_out  <= ctrl_out & ~KILL_MASK;
      end else if (!en) begin
         valid_out     <= valid_out;
         instr_out     <= instr_out;
         instr_raw_out <= instr_raw_out;
         data_out      <= data_out;
         ctrl_out      <= ctrl_out;
      end else if (stall) begin
         valid_out     <= 1'b0;
         instr_out     <= NOP_INSTR;
         instr_raw_out <= instr_in;
         data_out      <= data_in;
         ctrl_out      <= ctrl_in & ~KILL_MASK;
      end else begin
         valid_out     <= valid_in;
         instr_out     <= instr_in;
         instr_raw_out <= instr_in;
         data_out      <= data_in;
         ctrl_out      <= ctrl_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sticky_out <= '0;
      else     sticky_out <= sticky_in;
   end

`ifdef PIPE_STAGE_PERF_EN
   logic take_bubble;
   logic stage_loads;

   // A flush takes priority over a stall, so flush plus stall counts as
   // one bubble.
   assign take_bubble = flush | (en & stall);
   assign stage_loads = flush | en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt <= '0;
         hold_cnt   <= '0;
      end else begin
         if (take_bubble && !(&bubble_cnt))
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         if (stage_loads)
            hold_cnt <= '0;
         else if (!(&hold_cnt))
            hold_cnt <= hold_cnt + CNT_W'(1);
      end
   end
`else
   assign bubble_cnt = '0;
   assign hold_cnt   = '0;
`endif

endmodule
